// File: rtl/key_cmd_decoder.sv
// Groups debounced key presses separated by less than a gap window into one
// command carrying the press count, offered downstream over valid/ready.
module key_cmd_decoder #(
  parameter int CLK_PERIOD = 16,
  parameter int GAP_CYCLES = 500_000_000 / CLK_PERIOD,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_pulse,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [CNT_W-1:0] cmd_count,
  output logic             cmd_sat,
  output logic             cmd_lost,
  output logic             busy
);

  localparam int TMR_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [CNT_W-1:0]  count;
  logic              sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      count     <= '0;
      sat       <= 1'b0;
      cmd_valid <= 1'b0;
      cmd_count <= '0;
      cmd_sat   <= 1'b0;
      cmd_lost  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cmd_lost <= 1'b0;
      case (state)
        IDLE: begin
          if (key_pulse) begin
            state <= COLLECT;
            busy  <= 1'b1;
            count <= CNT_W'(1);
            timer <= '0;
            sat   <= 1'b0;
          end
        end

        COLLECT: begin
          // A press on the closing edge wins and extends the group.
          if (key_pulse) begin
            timer <= '0;
            if (count == MAX_CNT) begin
              sat <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end else if (timer == TMR_LAST) begin
            state     <= PRESENT;
            cmd_valid <= 1'b1;
            cmd_count <= count;
            cmd_sat   <= sat;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        PRESENT: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_count <= '0;
            cmd_sat   <= 1'b0;
            // A press on the accepting edge opens the next group directly.
            if (key_pulse) begin
              state <= COLLECT;
              count <= CNT_W'(1);
              timer <= '0;
              sat   <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              count <= '0;
              timer <= '0;
              sat   <= 1'b0;
            end
          end else if (key_pulse) begin
            cmd_lost <= 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          cmd_valid <= 1'b0;
          cmd_count <= '0;
          cmd_sat   <= 1'b0;
          count     <= '0;
          timer     <= '0;
          sat       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_cmd_decoder.sv
// Directed bench for key_cmd_decoder with a 10-cycle gap window and 3-bit count.
module tb_key_cmd_decoder;

  localparam int GAP = 10;
  localparam int CW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          key_pulse;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [CW-1:0] cmd_count;
  logic          cmd_sat;
  logic          cmd_lost;
  logic          busy;

  key_cmd_decoder #(
    .CLK_PERIOD(16),
    .GAP_CYCLES(GAP),
    .CNT_W     (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_pulse(key_pulse),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_count(cmd_count),
    .cmd_sat  (cmd_sat),
    .cmd_lost (cmd_lost),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          ev_n;
  int          ev_edge [8];
  int          ev_cnt  [8];
  int          ev_sat  [8];
  int          c_hist  [64];
  logic [63:0] v_hist, b_hist, l_hist;
  int          lost_n;
  logic        prev_v;

  localparam logic [63:0] ALL1 = '1;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Step i of a pattern drives the inputs sampled by edge E0+i, then records outputs.
  task automatic run(input logic [63:0] pulses, input logic [63:0] rdy, input int len);
    ev_n   = 0;
    lost_n = 0;
    v_hist = '0;
    b_hist = '0;
    l_hist = '0;
    prev_v = cmd_valid;
    for (int i = 0; i < len; i++) begin
      key_pulse = pulses[i];
      cmd_ready = rdy[i];
      @(posedge clk);
      #1;
      v_hist[i] = cmd_valid;
      b_hist[i] = busy;
      l_hist[i] = cmd_lost;
      c_hist[i] = int'(cmd_count);
      if (cmd_lost) lost_n++;
      if (cmd_valid && !prev_v && ev_n < 8) begin
        ev_edge[ev_n] = i;
        ev_cnt[ev_n]  = int'(cmd_count);
        ev_sat[ev_n]  = int'(cmd_sat);
        ev_n++;
      end
      prev_v = cmd_valid;
    end
    key_pulse = 1'b0;
    cmd_ready = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(cmd_valid), 0);
    check({tag, "_count"}, int'(cmd_count), 0);
    check({tag, "_sat"},   int'(cmd_sat),   0);
    check({tag, "_lost"},  int'(cmd_lost),  0);
    check({tag, "_busy"},  int'(busy),      0);
  endtask

  initial begin
    logic [63:0] p;

    rst_n     = 1'b0;
    key_pulse = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    #3 rst_n = 1'b1;

    // Single press
    run(64'h1, ALL1, 25);
    check("single_n",      ev_n, 1);
    check("single_edge",   ev_edge[0], 10);
    check("single_cnt",    ev_cnt[0], 1);
    check("single_sat",    ev_sat[0], 0);
    check("single_v9",     int'(v_hist[9]), 0);
    check("single_v11",    int'(v_hist[11]), 0);
    check("single_busy0",  int'(b_hist[0]), 1);
    check("single_busy11", int'(b_hist[11]), 0);

    // Triple press in one group
    p = (64'h1 << 0) | (64'h1 << 5) | (64'h1 << 14);
    run(p, ALL1, 35);
    check("triple_n",    ev_n, 1);
    check("triple_edge", ev_edge[0], 24);
    check("triple_cnt",  ev_cnt[0], 3);

    // Third press after the window closes
    p = (64'h1 << 0) | (64'h1 << 5) | (64'h1 << 20);
    run(p, ALL1, 40);
    check("split_n",     ev_n, 2);
    check("split_edge0", ev_edge[0], 15);
    check("split_cnt0",  ev_cnt[0], 2);
    check("split_edge1", ev_edge[1], 30);
    check("split_cnt1",  ev_cnt[1], 1);

    // Press on the closing edge extends the group
    p = (64'h1 << 0) | (64'h1 << 10);
    run(p, ALL1, 30);
    check("gap10_n",    ev_n, 1);
    check("gap10_edge", ev_edge[0], 20);
    check("gap10_cnt",  ev_cnt[0], 2);

    // Press on the accepting edge starts a new group
    p = (64'h1 << 0) | (64'h1 << 11);
    run(p, ALL1, 30);
    check("gap11_n",     ev_n, 2);
    check("gap11_edge0", ev_edge[0], 10);
    check("gap11_cnt0",  ev_cnt[0], 1);
    check("gap11_edge1", ev_edge[1], 21);
    check("gap11_cnt1",  ev_cnt[1], 1);

    // Nine presses saturate at 7
    p = '0;
    for (int k = 0; k < 9; k++) p[2*k] = 1'b1;
    run(p, ALL1, 30);
    check("sat_n",    ev_n, 1);
    check("sat_edge", ev_edge[0], 26);
    check("sat_cnt",  ev_cnt[0], 7);
    check("sat_flag", ev_sat[0], 1);

    run(64'h1, ALL1, 15);
    check("post_sat_cnt",  ev_cnt[0], 1);
    check("post_sat_flag", ev_sat[0], 0);

    // Backpressure: count-2 command held, two dropped presses, accept with a press
    p = (64'h1 << 0) | (64'h1 << 3) | (64'h1 << 15) | (64'h1 << 18) | (64'h1 << 22);
    run(p, ~((64'h1 << 22) - 64'h1), 36);
    check("bp_n",       ev_n, 2);
    check("bp_edge0",   ev_edge[0], 13);
    check("bp_cnt0",    ev_cnt[0], 2);
    check("bp_hold_v",  int'(v_hist[21]), 1);
    check("bp_hold_c",  c_hist[21], 2);
    check("bp_lost_n",  lost_n, 2);
    check("bp_lost15",  int'(l_hist[15]), 1);
    check("bp_lost16",  int'(l_hist[16]), 0);
    check("bp_lost18",  int'(l_hist[18]), 1);
    check("bp_lost22",  int'(l_hist[22]), 0);
    check("bp_v22",     int'(v_hist[22]), 0);
    check("bp_busy22",  int'(b_hist[22]), 1);
    check("bp_edge1",   ev_edge[1], 32);
    check("bp_cnt1",    ev_cnt[1], 1);

    // Reset during COLLECT (count 2, timer 6)
    p = (64'h1 << 0) | (64'h1 << 4);
    run(p, ALL1, 11);
    check("rc_busy_pre", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rc");
    #2 rst_n = 1'b1;
    run(64'h0, ALL1, 20);
    check("rc_after_n",    ev_n, 0);
    check("rc_after_busy", int'(b_hist[19:0] != 20'h0), 0);

    // Reset during PRESENT
    run(64'h1, 64'h0, 12);
    check("rp_valid_pre", int'(cmd_valid), 1);
    check("rp_cnt_pre",   int'(cmd_count), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rp");
    #2 rst_n = 1'b1;
    run(64'h0, ALL1, 20);
    check("rp_after_n",    ev_n, 0);
    check("rp_after_busy", int'(b_hist[19:0] != 20'h0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_cmd_decoder.md
Name: key_cmd_decoder

Overview:
- Consumer of the one-cycle debounced press strobe produced by the button debouncer.
- Groups presses separated by less than a gap window into a single command (1 press, 2 presses, ...). Hands the press count to the control logic (e.g. PAM4/RGB mode select) over a valid/ready handshake.
- Flags presses lost while a command is waiting to be accepted, and flags press counts that saturate.

Parameters:
- CLK_PERIOD, 16, input clock period in ns (62.5 MHz); informational, used to derive the default GAP_CYCLES.
- GAP_CYCLES, 31_250_000, idle cycles after the last press that close a group (500 ms at 16 ns); must be >= 2.
- CNT_W, 3, width of the press count; maximum count MAX_CNT = 2^CNT_W - 1.
- TMR_W, ceil(log2(GAP_CYCLES)), timer width; derived localparam, not to be overridden.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_pulse  input  1  debounced press strobe, one cycle high per press, synchronous to clk.
- cmd_valid  output  1  a command is presented; held until accepted.
- cmd_ready  input  1  downstream accepts the command when cmd_valid and cmd_ready are both high at an edge.
- cmd_count  output  CNT_W  number of presses in the group; stable while cmd_valid is high.
- cmd_sat  output  1  group reached MAX_CNT, at least one further press was ignored; qualifies cmd_count, stable while cmd_valid is high.
- cmd_lost  output  1  one-cycle pulse: a key_pulse was dropped because a command was pending.
- busy  output  1  high in COLLECT or PRESENT.

Behaviour:
- Reset (async assert, sync release): state IDLE, timer 0, count 0.
  - All outputs 0: cmd_valid, cmd_count, cmd_sat, cmd_lost, busy.
  - Reset mid-group or mid-present discards the group; no command is issued after release.
- States: IDLE, COLLECT, PRESENT. All outputs are registered.
- IDLE:
  - key_pulse -> COLLECT, count = 1, timer = 0, sat = 0.
  - Otherwise stay.
- COLLECT, each edge:
  - key_pulse: timer = 0.
    - count < MAX_CNT -> count + 1.
    - count == MAX_CNT -> count holds, sat = 1. Count never wraps.
  - No pulse, timer == GAP_CYCLES-1: -> PRESENT, cmd_valid = 1, cmd_count = count, cmd_sat = sat.
  - No pulse, otherwise: timer + 1.
  - A pulse on the same edge where timer == GAP_CYCLES-1 wins: the group is extended and the timer restarts.
  - Resulting latency: cmd_valid rises exactly GAP_CYCLES edges after the edge that sampled the last press.
- PRESENT:
  - cmd_valid, cmd_count, cmd_sat held stable until the handshake.
  - Handshake edge with no key_pulse -> IDLE; cmd_valid = 0, cmd_count = 0, cmd_sat = 0.
  - Handshake edge with key_pulse -> COLLECT with count = 1, timer = 0. The press is not lost and cmd_lost stays 0.
  - key_pulse without handshake -> press dropped, cmd_lost = 1 on the next cycle only. Each dropped press gives its own pulse.
- cmd_ready while cmd_valid is low is ignored.
- busy = (state != IDLE), registered together with the state.
- Timer width TMR_W holds GAP_CYCLES-1 without overflow. Comparisons are unsigned.

Test Plan (GAP_CYCLES=10, CNT_W=3, cmd_ready tied 1 unless stated):
- Single press: one key_pulse at edge E0 -> cmd_valid high only at edge E0+10 with cmd_count=1, cmd_sat=0; cmd_valid low and state IDLE at E0+11.
- Triple press: pulses at E0, E0+5, E0+14 -> exactly one command, cmd_count=3, cmd_valid rises at E0+24. Same stimulus with the third pulse at E0+20 -> two commands: count 2 at E0+15, count 1 at E0+30.
- Gap boundary: pulses at E0 and E0+10 -> one command, count=2, valid at E0+20. Pulses at E0 and E0+11 -> two commands, count 1 then count 1.
- Saturation: 9 pulses spaced 2 cycles apart -> cmd_count=7, cmd_sat=1. A following single press gives cmd_count=1, cmd_sat=0.
- Backpressure: cmd_ready=0 after a count-2 command is presented, then 2 pulses -> cmd_count stays 2, two separate cmd_lost pulses. Raise cmd_ready together with a third pulse -> handshake, the new group starts, and its command has count=1.
- Reset: assert rst_n=0 during COLLECT (count 2, timer 6) and again during PRESENT -> all outputs 0 immediately (asynchronously). No command appears within 20 cycles after release without new presses.
